irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Memory-mapped, parametrised interrupt controller between peripheral event pulses
//  (ethernet receive_ack, VGA, timers, ...) and the CPU54 intr/inta pair. Replaces the
//  single hand-built intr latch in the top level: NUM_SRC sources, each with its own
//  pending bit, mask, and edge/level trigger mode, plus a fixed-priority claim register.
//  Sits behind io_sel on the data bus: its cs is one io_sel select, rdata is muxed into CPU rdata.
// PARAMETERS
//  NUM_SRC  4  number of interrupt sources, 1..16; source 0 has highest priority
//  ID_W     4  width of the source ID field; must satisfy 2**ID_W >= NUM_SRC
// PORTS
//  clk    in   1        CPU clock; only clock in the block
//  rst    in   1        reset, asynchronous, active-low
//  src    in   NUM_SRC  interrupt request lines, one per source
//  cs     in   1        block select from io_sel
//  we     in   1        bus write strobe (DM_W)
//  re     in   1        bus read strobe (DM_R)
//  addr   in   3        word address, byte addr[4:2]
//  wdata  in   32       bus write data
//  rdata  out  32       bus read data, combinational from addr
//  intr   out  1        interrupt request to CPU, registered
//  inta   in   1        CPU interrupt acknowledge, one-cycle pulse
//  irq_id out  ID_W     source ID latched on inta
// BEHAVIOUR
//  Register map (byte offset): 0x00 PEND (R, W1C), 0x04 MASK (RW), 0x08 CLAIM (R),
//   0x0C CTRL (RW, bit0 GEN global enable), 0x10 TRIG (RW, 1=level, 0=edge per bit).
//   0x14..0x1C read 0, writes ignored. Bits >= NUM_SRC read 0, writes ignored.
//  Reset: PEND, MASK, CTRL, TRIG, src_prev, intr, irq_id all 0.
//  Edge source: src & ~src_prev sets PEND bit at the next clk edge; src_prev registered.
//   A source held high through reset release latches PEND one cycle later.
//  Level source: PEND bit = src each cycle (registered); W1C and claim have no effect.
//  W1C: cs & we & addr==PEND clears bits where wdata=1 (edge sources only).
//  Set and clear of the same PEND bit in the same cycle: set wins, bit stays 1.
//  active = PEND & MASK; best = lowest index set in active.
//  CLAIM read (cs & re & addr==CLAIM): rdata = {valid, 27'b0, best} when active != 0,
//   else 0. At the clk edge of that read, PEND[best] is cleared (edge sources only);
//   the set-wins rule applies. Writes to CLAIM are ignored.
//  rdata = 0 when cs & re is low.
//  intr <= GEN & |active; one cycle latency from the PEND update, two from the src edge.
//  inta: irq_id <= best (0 if active == 0); no PEND side effect. inta while intr=0 is
//   harmless and only updates irq_id.
//  Reset asserted mid-operation: all state clears immediately; pending events are lost.
// CONFIGURATION
//  IRQ_SYNC_EN defined: each src bit goes through a 2-flop synchroniser (reset 0) before
//   the edge/level logic; adds 2 cycles to every src-to-PEND latency. Use it for sources
//   from another clock domain, e.g. ethernet on clk_in.
//  IRQ_SYNC_EN undefined: src is used directly and must be synchronous to clk.
// TESTING
//  1 Reset: hold rst=0, toggle src -> PEND, MASK, intr, irq_id, rdata all 0; after release,
//    src[0] already high -> PEND=0x1 one cycle later.
//  2 Edge + mask: MASK=0x4, CTRL=1, pulse src[2] one cycle -> PEND=0x4, intr=1 two cycles
//    after the pulse; CLAIM read = 0x80000002, then PEND=0, intr=0 the following cycle.
//  3 Priority: MASK=0xF, CTRL=1, pulse src[3] and src[1] together -> CLAIM reads 0x80000001,
//    then 0x80000003, then 0x00000000.
//  4 Collision: W1C 0x1 to PEND in the same cycle as a new src[0] edge -> PEND[0] stays 1,
//    intr stays 1.
//  5 Level mode: TRIG=0x2, MASK=0x2, CTRL=1, hold src[1]=1 -> CLAIM and W1C leave PEND[1]=1;
//    drop src[1] -> PEND[1]=0, then intr=0 one cycle later; inta while high -> irq_id=1.
//  6 IRQ_SYNC_EN build: repeat test 2 -> PEND set 2 cycles later than the base build.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: io_sel-decoded data-bus slice between the CPU and the interrupt controller.
// master = CPU/bus side, slave = irq_ctrl.
interface irq_ctrl_if;
   logic        cs;
   logic        we;
   logic        re;
   logic [2:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (
      output cs,
      output we,
      output re,
      output addr,
      output wdata,
      input  rdata
   );

   modport slave (
      input  cs,
      input  we,
      input  re,
      input  addr,
      input  wdata,
      output rdata
   );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller with per-source pending, mask and edge/level
// trigger, plus a fixed-priority claim register. Define IRQ_SYNC_EN to synchronise src_i.
module irq_ctrl #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned ID_W    = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_SRC-1:0] src_i,
   irq_ctrl_if.slave          bus,
   output logic               intr_o,
   input  logic               inta_i,
   output logic [ID_W-1:0]    irq_id_o
);

   localparam logic [2:0] AddrPend  = 3'd0;
   localparam logic [2:0] AddrMask  = 3'd1;
   localparam logic [2:0] AddrClaim = 3'd2;
   localparam logic [2:0] AddrCtrl  = 3'd3;
   localparam logic [2:0] AddrTrig  = 3'd4;

   logic [NUM_SRC-1:0] src_s;
   logic [NUM_SRC-1:0] src_prev_q;
   logic [NUM_SRC-1:0] pend_q, pend_d;
   logic [NUM_SRC-1:0] mask_q, mask_d;
   logic [NUM_SRC-1:0] trig_q, trig_d;
   logic               gen_q, gen_d;
   logic               intr_q, intr_d;
   logic [ID_W-1:0]    irq_id_q, irq_id_d;

   logic [NUM_SRC-1:0] active;
   logic [NUM_SRC-1:0] edge_set;
   logic [NUM_SRC-1:0] w1c_clr;
   logic [NUM_SRC-1:0] claim_clr;
   logic [ID_W-1:0]    best;
   logic               valid;
   logic               bus_wr;
   logic               bus_rd;
   logic [31:0]        rdata;
   logic               unused_wdata;

`ifdef IRQ_SYNC_EN
   logic [NUM_SRC-1:0] sync1_q;
   logic [NUM_SRC-1:0] sync2_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= src_i;
         sync2_q <= sync1_q;
      end
   end

   assign src_s = sync2_q;
`else
   assign src_s = src_i;
`endif

   // Only the low NUM_SRC bits (and bit 0 for CTRL) of write data are architected.
   assign unused_wdata = ^bus.wdata;

   always_comb begin
      bus_wr = bus.cs & bus.we;
      bus_rd = bus.cs & bus.re;
      active = pend_q & mask_q;
      valid  = |active;

      // Walk downwards so the lowest active index is the last one written.
      best = '0;
      for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
         if (active[i]) best = ID_W'(i);
      end

      edge_set  = src_s & ~src_prev_q;
      w1c_clr   = (bus_wr && bus.addr == AddrPend) ? bus.wdata[NUM_SRC-1:0] : '0;
      // Isolate the lowest set bit of active: the source being claimed.
      claim_clr = (bus_rd && bus.addr == AddrClaim) ?
                  (active & ~(active - NUM_SRC'(1))) : '0;

      // Level bits track src; edge bits hold, clear, then set (set wins a collision).
      pend_d = (trig_q & src_s) |
               (~trig_q & ((pend_q & ~(w1c_clr | claim_clr)) | edge_set));

      mask_d = mask_q;
      trig_d = trig_q;
      gen_d  = gen_q;
      if (bus_wr) begin
         case (bus.addr)
            AddrMask: mask_d = bus.wdata[NUM_SRC-1:0];
            AddrCtrl: gen_d  = bus.wdata[0];
            AddrTrig: trig_d = bus.wdata[NUM_SRC-1:0];
            default:  ;
         endcase
      end

      intr_d   = gen_q & valid;
      irq_id_d = inta_i ? best : irq_id_q;
   end

   always_comb begin
      rdata = '0;
      if (bus_rd) begin
         case (bus.addr)
            AddrPend:  rdata = 32'(pend_q);
            AddrMask:  rdata = 32'(mask_q);
            AddrClaim: rdata = valid ? {1'b1, 31'(best)} : 32'h0;
            AddrCtrl:  rdata = {31'b0, gen_q};
            AddrTrig:  rdata = 32'(trig_q);
            default:   rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         src_prev_q <= '0;
         pend_q     <= '0;
         mask_q     <= '0;
         trig_q     <= '0;
         gen_q      <= 1'b0;
         intr_q     <= 1'b0;
         irq_id_q   <= '0;
      end else begin
         src_prev_q <= src_s;
         pend_q     <= pend_d;
         mask_q     <= mask_d;
         trig_q     <= trig_d;
         gen_q      <= gen_d;
         intr_q     <= intr_d;
         irq_id_q   <= irq_id_d;
      end
   end

   assign bus.rdata = rdata;
   assign intr_o    = intr_q;
   assign irq_id_o  = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl; tracks the IRQ_SYNC_EN latency.
module tb_irq_ctrl;

   localparam int unsigned NUM_SRC = 4;
   localparam int unsigned ID_W    = 4;
`ifdef IRQ_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif

   localparam logic [2:0] APend  = 3'd0;
   localparam logic [2:0] AMask  = 3'd1;
   localparam logic [2:0] AClaim = 3'd2;
   localparam logic [2:0] ACtrl  = 3'd3;
   localparam logic [2:0] ATrig  = 3'd4;

   logic               clk_i = 1'b0;
   logic               rst_ni;
   logic [NUM_SRC-1:0] src_i;
   logic               intr_o;
   logic               inta_i;
   logic [ID_W-1:0]    irq_id_o;

   int n_tests = 0;
   int n_fail  = 0;

   irq_ctrl_if bus ();

   irq_ctrl #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .src_i    (src_i),
      .bus      (bus),
      .intr_o   (intr_o),
      .inta_i   (inta_i),
      .irq_id_o (irq_id_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_i);
         @(negedge clk_i);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
      tick(1);
      bus.cs = 1'b0; bus.we = 1'b0; bus.wdata = '0;
   endtask

   // Read across one clock edge, so CLAIM side effects take place.
   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      bus.cs = 1'b1; bus.re = 1'b1; bus.addr = a;
      #1 d = bus.rdata;
      tick(1);
      bus.cs = 1'b0; bus.re = 1'b0;
   endtask

   // Combinational look at rdata with no clock edge in between: no side effects.
   task automatic peek(input logic [2:0] a, output logic [31:0] d);
      bus.cs = 1'b1; bus.re = 1'b1; bus.addr = a;
      #1 d = bus.rdata;
      bus.cs = 1'b0; bus.re = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      rst_ni = 1'b0; src_i = '0; inta_i = 1'b0;
      bus.cs = 1'b0; bus.we = 1'b0; bus.re = 1'b0; bus.addr = '0; bus.wdata = '0;

      // Reset: toggling src while held in reset leaves everything clear.
      @(negedge clk_i);
      src_i = 4'b1010; tick(2);
      src_i = 4'b0101; tick(1);
      peek(APend, d);  check("rst_pend", d, 32'h0);
      peek(AMask, d);  check("rst_mask", d, 32'h0);
      check("rst_intr", 32'(intr_o), 32'h0);
      check("rst_irq_id", 32'(irq_id_o), 32'h0);
      src_i = 4'b0001;
      rst_ni = 1'b1;
      peek(APend, d);  check("rel_pend_before", d, 32'h0);
      tick(1 + SL);
      peek(APend, d);  check("rel_pend_after", d, 32'h1);
      src_i = '0;
      wr(APend, 32'h1);
      peek(APend, d);  check("w1c_clear", d, 32'h0);

      // Edge + mask.
      wr(AMask, 32'h4);
      wr(ACtrl, 32'h1);
      src_i = 4'b0100; tick(1);
      src_i = '0; tick(SL);
      peek(APend, d);  check("edge_pend", d, 32'h4);
      check("edge_intr_lat1", 32'(intr_o), 32'h0);
      tick(1);
      check("edge_intr_lat2", 32'(intr_o), 32'h1);
      rd(AClaim, d);   check("edge_claim", d, 32'h8000_0002);
      peek(APend, d);  check("edge_pend_claimed", d, 32'h0);
      tick(1);
      check("edge_intr_drop", 32'(intr_o), 32'h0);

      // Priority between two simultaneous edges.
      wr(AMask, 32'hF);
      src_i = 4'b1010; tick(1);
      src_i = '0; tick(SL + 1);
      check("prio_intr", 32'(intr_o), 32'h1);
      rd(AClaim, d);   check("prio_claim1", d, 32'h8000_0001);
      rd(AClaim, d);   check("prio_claim3", d, 32'h8000_0003);
      rd(AClaim, d);   check("prio_claim_none", d, 32'h0);

      // Collision of W1C with a new edge on the same bit.
      src_i = 4'b0001; tick(1);
      src_i = '0; tick(SL + 1);
      peek(APend, d);  check("coll_pre_pend", d, 32'h1);
      check("coll_pre_intr", 32'(intr_o), 32'h1);
      src_i = 4'b0001; tick(SL);
      wr(APend, 32'h1);
      peek(APend, d);  check("coll_pend", d, 32'h1);
      check("coll_intr", 32'(intr_o), 32'h1);
      src_i = '0;
      wr(APend, 32'h1);
      peek(APend, d);  check("coll_cleanup", d, 32'h0);
      tick(1);
      check("coll_intr_drop", 32'(intr_o), 32'h0);

      // Level mode on source 1.
      wr(ATrig, 32'h2);
      wr(AMask, 32'h2);
      src_i = 4'b0010; tick(SL + 1);
      peek(APend, d);  check("lvl_pend", d, 32'h2);
      tick(1);
      check("lvl_intr", 32'(intr_o), 32'h1);
      rd(AClaim, d);   check("lvl_claim", d, 32'h8000_0001);
      peek(APend, d);  check("lvl_pend_after_claim", d, 32'h2);
      wr(APend, 32'h2);
      peek(APend, d);  check("lvl_pend_after_w1c", d, 32'h2);
      inta_i = 1'b1; tick(1); inta_i = 1'b0;
      check("lvl_irq_id", 32'(irq_id_o), 32'h1);
      src_i = '0; tick(SL + 1);
      peek(APend, d);  check("lvl_pend_drop", d, 32'h0);
      check("lvl_intr_hold", 32'(intr_o), 32'h1);
      tick(1);
      check("lvl_intr_drop", 32'(intr_o), 32'h0);
      inta_i = 1'b1; tick(1); inta_i = 1'b0;
      check("inta_idle_irq_id", 32'(irq_id_o), 32'h0);

      // Register map corners.
      wr(AMask, 32'hFFFF_FFFF);
      rd(AMask, d);    check("mask_width", d, 32'hF);
      peek(ACtrl, d);  check("ctrl_read", d, 32'h1);
      peek(ATrig, d);  check("trig_read", d, 32'h2);
      wr(3'd5, 32'hFFFF_FFFF);
      peek(3'd5, d);   check("unmapped_read", d, 32'h0);
      bus.cs = 1'b1; bus.re = 1'b0; bus.addr = AMask;
      #1 check("no_re_rdata", bus.rdata, 32'h0);
      bus.cs = 1'b0;

      // Reset mid-operation with an interrupt outstanding.
      wr(ATrig, 32'h0);
      src_i = 4'b0100; tick(1);
      src_i = '0; tick(SL + 1);
      check("mid_intr_pre", 32'(intr_o), 32'h1);
      rst_ni = 1'b0;
      peek(APend, d);  check("mid_rst_pend", d, 32'h0);
      peek(AMask, d);  check("mid_rst_mask", d, 32'h0);
      check("mid_rst_intr", 32'(intr_o), 32'h0);
      tick(1);
      rst_ni = 1'b1;
      tick(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
